// File: rtl/isp8_ext_bus_ctrl.sv
// rtl/isp8_ext_bus_ctrl.sv - external I/O and scratchpad bus master with wait states, ack and timeout
module isp8_ext_bus_ctrl #(
  parameter int PORT_AW     = 8,
  parameter int WAIT_CYC    = 0,
  parameter int USE_ACK     = 0,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_io_wr,
  input  logic               req_io_rd,
  input  logic               req_mem_wr,
  input  logic               req_mem_rd,
  input  logic [PORT_AW-1:0] req_addr,
  input  logic [7:0]         req_wdata,
  input  logic               err_clr,
  input  logic               ext_ack,
  input  logic [7:0]         ext_din,
  output logic [PORT_AW-1:0] ext_addr,
  output logic [7:0]         ext_dout,
  output logic               ext_io_wr,
  output logic               ext_io_rd,
  output logic               ext_mem_wr,
  output logic               ext_mem_rd,
  output logic               busy,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic               timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW:0]   WAIT_V  = (CW + 1)'(WAIT_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic          ACK_EN  = (USE_ACK != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  // Latched cycle type, one-hot: [3] mem_wr, [2] mem_rd, [1] io_wr, [0] io_rd
  logic [3:0]    kind;
  logic [3:0]    sel;
  logic [3:0]    strb;
  logic [CW:0]   cnt_p1;
  logic          wait_met, done, timeout_hit;
  logic          accept, finish, tmo;

  assign cnt_p1      = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
  // cnt+1 > WAIT_CYC is cnt >= WAIT_CYC without a constant compare against zero
  assign wait_met    = (cnt_p1 > WAIT_V);
  assign done        = wait_met && (!ACK_EN || ext_ack);
  assign timeout_hit = ACK_EN && (cnt == TO_LAST);

  assign busy       = (state != S_IDLE);
  assign ext_mem_wr = strb[3];
  assign ext_mem_rd = strb[2];
  assign ext_io_wr  = strb[1];
  assign ext_io_rd  = strb[0];

  // Fixed-priority request select: mem_wr > mem_rd > io_wr > io_rd
  always_comb begin
    sel = 4'b0000;
    if (req_mem_wr)      sel = 4'b1000;
    else if (req_mem_rd) sel = 4'b0100;
    else if (req_io_wr)  sel = 4'b0010;
    else if (req_io_rd)  sel = 4'b0001;
  end

  // State register and strobe-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; a completing cycle wins over a timeout in the same cycle
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    finish   = 1'b0;
    tmo      = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel != 4'b0000) begin
          accept   = 1'b1;
          state_nx = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_nx   = '0;
        state_nx = S_STROBE;
      end
      S_STROBE: begin
        if (done) begin
          finish   = 1'b1;
          state_nx = S_IDLE;
        end else if (timeout_hit) begin
          finish   = 1'b1;
          tmo      = 1'b1;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Bus datapath: address/data latch, registered strobes, read capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_addr <= '0;
      ext_dout <= '0;
      kind     <= '0;
      strb     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (accept) begin
        ext_addr <= req_addr;
        ext_dout <= req_wdata;
        kind     <= sel;
      end
      if (state == S_SETUP) begin
        strb <= kind;
      end
      if (finish) begin
        strb <= '0;
        if (kind[2] || kind[0]) begin
          rd_valid <= 1'b1;
          rd_data  <= tmo ? 8'hFF : ext_din;
        end
      end
    end
  end

  // Sticky timeout flag; a new timeout beats a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err <= 1'b0;
    end else if (tmo) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_isp8_ext_bus_ctrl.sv
// tb/tb_isp8_ext_bus_ctrl.sv - self-checking bench for isp8_ext_bus_ctrl over three parameter sets
module tb_isp8_ext_bus_ctrl;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_io_wr = 1'b0, req_io_rd = 1'b0, req_mem_wr = 1'b0, req_mem_rd = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0, ext_din = '0;
  logic       err_clr = 1'b0, ext_ack = 1'b0;

  logic [7:0] o_addr [N];
  logic [7:0] o_dout [N];
  logic [7:0] o_rdd  [N];
  logic       o_iow [N], o_ior [N], o_mw [N], o_mr [N], o_busy [N], o_rdv [N], o_err [N];

  int compared = 0;
  int mismatched = 0;

  // Observations per instance for the last transaction
  int         ob_cnt [N][4];
  int         ob_first [N], ob_last [N], ob_busy [N], ob_rdv [N], ob_rdv_idx [N];
  logic [7:0] ob_rdd [N], ob_addr1 [N], ob_dout1 [N], ob_addr_end [N];
  logic       ob_err [N];
  // Model expectations
  int         ex_width [N];
  logic       ex_tmo [N];
  logic       ex_err [N];
  int         ex_ki;
  logic       ex_rd;

  always #5 clk = ~clk;

  isp8_ext_bus_ctrl #(.PORT_AW(8), .WAIT_CYC(0), .USE_ACK(0), .TIMEOUT_CYC(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_io_wr(req_io_wr), .req_io_rd(req_io_rd),
    .req_mem_wr(req_mem_wr), .req_mem_rd(req_mem_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .err_clr(err_clr), .ext_ack(ext_ack), .ext_din(ext_din), .ext_addr(o_addr[0]), .ext_dout(o_dout[0]),
    .ext_io_wr(o_iow[0]), .ext_io_rd(o_ior[0]), .ext_mem_wr(o_mw[0]), .ext_mem_rd(o_mr[0]),
    .busy(o_busy[0]), .rd_data(o_rdd[0]), .rd_valid(o_rdv[0]), .timeout_err(o_err[0]));

  isp8_ext_bus_ctrl #(.PORT_AW(8), .WAIT_CYC(3), .USE_ACK(0), .TIMEOUT_CYC(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_io_wr(req_io_wr), .req_io_rd(req_io_rd),
    .req_mem_wr(req_mem_wr), .req_mem_rd(req_mem_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .err_clr(err_clr), .ext_ack(ext_ack), .ext_din(ext_din), .ext_addr(o_addr[1]), .ext_dout(o_dout[1]),
    .ext_io_wr(o_iow[1]), .ext_io_rd(o_ior[1]), .ext_mem_wr(o_mw[1]), .ext_mem_rd(o_mr[1]),
    .busy(o_busy[1]), .rd_data(o_rdd[1]), .rd_valid(o_rdv[1]), .timeout_err(o_err[1]));

  isp8_ext_bus_ctrl #(.PORT_AW(8), .WAIT_CYC(1), .USE_ACK(1), .TIMEOUT_CYC(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_io_wr(req_io_wr), .req_io_rd(req_io_rd),
    .req_mem_wr(req_mem_wr), .req_mem_rd(req_mem_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .err_clr(err_clr), .ext_ack(ext_ack), .ext_din(ext_din), .ext_addr(o_addr[2]), .ext_dout(o_dout[2]),
    .ext_io_wr(o_iow[2]), .ext_io_rd(o_ior[2]), .ext_mem_wr(o_mw[2]), .ext_mem_rd(o_mr[2]),
    .busy(o_busy[2]), .rd_data(o_rdd[2]), .rd_valid(o_rdv[2]), .timeout_err(o_err[2]));

  function automatic int p_wait(int n);
    return (n == 0) ? 0 : (n == 1) ? 3 : 1;
  endfunction
  function automatic bit p_ack(int n);
    return (n == 2);
  endfunction
  function automatic int p_to(int n);
    return (n == 2) ? 8 : 64;
  endfunction

  // Drive one request (ack rises in strobe cycle k, 0 = never) and record 20 cycles of bus activity
  task automatic run_txn(input logic [3:0] mask, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] din, input int k, input int clr_at, input bit busy_req);
    int need;
    @(negedge clk);
    {req_mem_wr, req_mem_rd, req_io_wr, req_io_rd} = mask;
    req_addr = addr; req_wdata = wdata; ext_din = din; ext_ack = 1'b0;
    ex_ki = mask[3] ? 3 : mask[2] ? 2 : mask[1] ? 1 : 0;
    ex_rd = (ex_ki == 2) || (ex_ki == 0);
    for (int n = 0; n < N; n++) begin
      ex_tmo[n] = 1'b0;
      if (p_ack(n)) begin
        need = (k == 0) ? 1000 : k;
        if (need < p_wait(n) + 1) need = p_wait(n) + 1;
        if (need > p_to(n)) begin
          ex_width[n] = p_to(n);
          ex_tmo[n] = 1'b1;
        end else begin
          ex_width[n] = need;
        end
      end else begin
        ex_width[n] = p_wait(n) + 1;
      end
      if (ex_tmo[n]) ex_err[n] = 1'b1;
      else if (clr_at != 0) ex_err[n] = 1'b0;
      for (int b = 0; b < 4; b++) ob_cnt[n][b] = 0;
      ob_first[n] = 0; ob_last[n] = 0; ob_busy[n] = 0; ob_rdv[n] = 0; ob_rdv_idx[n] = 0;
      ob_rdd[n] = '0;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      for (int n = 0; n < N; n++) begin
        automatic logic [3:0] sv = {o_mw[n], o_mr[n], o_iow[n], o_ior[n]};
        for (int b = 0; b < 4; b++) if (sv[b]) ob_cnt[n][b]++;
        if (sv != 4'b0000) begin
          if (ob_first[n] == 0) ob_first[n] = i;
          ob_last[n] = i;
        end
        if (o_busy[n]) ob_busy[n]++;
        if (o_rdv[n]) begin
          ob_rdv[n]++;
          ob_rdv_idx[n] = i;
          ob_rdd[n] = o_rdd[n];
        end
        if (i == 1) begin
          ob_addr1[n] = o_addr[n];
          ob_dout1[n] = o_dout[n];
        end
        if (i == 20) begin
          ob_addr_end[n] = o_addr[n];
          ob_err[n] = o_err[n];
        end
      end
      if (i == 1) begin
        {req_mem_wr, req_mem_rd, req_io_wr, req_io_rd} = busy_req ? 4'b0010 : 4'b0000;
        req_addr = ~addr; req_wdata = ~wdata;
      end else if (i == 2) begin
        {req_mem_wr, req_mem_rd, req_io_wr, req_io_rd} = 4'b0000;
      end
      ext_ack = (k != 0) && (i - 1 >= k);
      err_clr = (clr_at != 0) && (i == clr_at);
    end
    ext_ack = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #23;
    for (int n = 0; n < N; n++) begin
      compared++;
      if ({o_iow[n], o_ior[n], o_mw[n], o_mr[n], o_busy[n], o_rdv[n], o_err[n]} !== 7'b0 ||
          o_addr[n] !== 8'h00 || o_dout[n] !== 8'h00 || o_rdd[n] !== 8'h00) begin
        mismatched++;
        $display("FAIL reset inst%0d: flags=%b addr=%h dout=%h rdd=%h, required all zero", n,
                 {o_iow[n], o_ior[n], o_mw[n], o_mr[n], o_busy[n], o_rdv[n], o_err[n]},
                 o_addr[n], o_dout[n], o_rdd[n]);
      end
      ex_err[n] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_min_latency_write();
    run_txn(4'b0010, 8'h12, 8'hA5, 8'h00, 1, 0, 1'b0);
    compared++;
    if (ob_cnt[0][1] !== 1 || ob_first[0] !== 2) begin
      mismatched++;
      $display("FAIL io_wr_strobe: width=%0d first=%0d, required width=1 first=2", ob_cnt[0][1], ob_first[0]);
    end
    compared++;
    if (ob_addr1[0] !== 8'h12 || ob_dout1[0] !== 8'hA5) begin
      mismatched++;
      $display("FAIL io_wr_setup: addr=%h dout=%h, required 12/A5", ob_addr1[0], ob_dout1[0]);
    end
    compared++;
    if (ob_busy[0] !== 2 || ob_rdv[0] !== 0) begin
      mismatched++;
      $display("FAIL io_wr_busy: busy=%0d rdv=%0d, required 2/0", ob_busy[0], ob_rdv[0]);
    end
  endtask

  task automatic test_wait_states();
    run_txn(4'b0100, 8'h40, 8'h00, 8'h3C, 1, 0, 1'b0);
    compared++;
    if (ob_cnt[1][2] !== 4 || ob_first[1] !== 2) begin
      mismatched++;
      $display("FAIL mem_rd_wait: width=%0d first=%0d, required 4/2", ob_cnt[1][2], ob_first[1]);
    end
    compared++;
    if (ob_rdv[1] !== 1 || ob_rdv_idx[1] !== 6 || ob_rdd[1] !== 8'h3C) begin
      mismatched++;
      $display("FAIL mem_rd_data: pulses=%0d at=%0d data=%h, required 1 at 6 data 3C",
               ob_rdv[1], ob_rdv_idx[1], ob_rdd[1]);
    end
  endtask

  task automatic test_ack();
    run_txn(4'b0001, 8'h07, 8'h00, 8'h5E, 5, 0, 1'b0);
    compared++;
    if (ob_cnt[2][0] !== 5 || ob_rdd[2] !== 8'h5E || ob_rdv[2] !== 1 || ob_err[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL ack_io_rd: width=%0d data=%h pulses=%0d err=%b, required 5/5E/1/0",
               ob_cnt[2][0], ob_rdd[2], ob_rdv[2], ob_err[2]);
    end
    // Ack present but wait states not yet met: wait dominates
    run_txn(4'b0001, 8'h08, 8'h00, 8'h66, 1, 0, 1'b0);
    compared++;
    if (ob_cnt[2][0] !== 2) begin
      mismatched++;
      $display("FAIL ack_early: width=%0d, required 2", ob_cnt[2][0]);
    end
    // Ack on the very last allowed cycle completes normally
    run_txn(4'b0001, 8'h09, 8'h00, 8'h77, 8, 0, 1'b0);
    compared++;
    if (ob_cnt[2][0] !== 8 || ob_rdd[2] !== 8'h77 || ob_err[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL ack_last_cycle: width=%0d data=%h err=%b, required 8/77/0", ob_cnt[2][0], ob_rdd[2], ob_err[2]);
    end
  endtask

  task automatic test_timeout();
    run_txn(4'b0001, 8'h20, 8'h00, 8'h11, 0, 0, 1'b0);
    compared++;
    if (ob_cnt[2][0] !== 8 || ob_rdd[2] !== 8'hFF || ob_rdv[2] !== 1 || ob_err[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_rd: width=%0d data=%h pulses=%0d err=%b, required 8/FF/1/1",
               ob_cnt[2][0], ob_rdd[2], ob_rdv[2], ob_err[2]);
    end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    for (int n = 0; n < N; n++) ex_err[n] = 1'b0;
    compared++;
    if (o_err[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL err_clr: err=%b, required 0", o_err[2]);
    end
    // err_clr lands on the same edge as the next timeout
    run_txn(4'b0010, 8'h21, 8'h99, 8'h00, 0, 9, 1'b0);
    compared++;
    if (ob_cnt[2][1] !== 8 || ob_rdv[2] !== 0 || ob_err[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_wr_clr: width=%0d pulses=%0d err=%b, required 8/0/1", ob_cnt[2][1], ob_rdv[2], ob_err[2]);
    end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    for (int n = 0; n < N; n++) ex_err[n] = 1'b0;
  endtask

  task automatic test_priority_busy();
    run_txn(4'b1001, 8'h33, 8'hC3, 8'h00, 2, 0, 1'b1);
    for (int n = 0; n < N; n++) begin
      compared++;
      if (ob_cnt[n][3] !== ex_width[n] || ob_cnt[n][0] !== 0 || ob_cnt[n][1] !== 0 ||
          ob_addr_end[n] !== 8'h33 || ob_busy[n] !== ex_width[n] + 1) begin
        mismatched++;
        $display("FAIL priority_busy inst%0d: mw=%0d ior=%0d iow=%0d addr=%h busy=%0d, required %0d/0/0/33/%0d",
                 n, ob_cnt[n][3], ob_cnt[n][0], ob_cnt[n][1], ob_addr_end[n], ob_busy[n],
                 ex_width[n], ex_width[n] + 1);
      end
    end
  endtask

  task automatic test_reset_mid_cycle();
    int rdv_seen = 0;
    @(negedge clk);
    req_mem_rd = 1'b1; req_addr = 8'h55; ext_din = 8'h44; ext_ack = 1'b0;
    @(negedge clk); req_mem_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (o_mr[1] !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_pre: mem_rd=%b, required 1", o_mr[1]);
    end
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < N; n++) begin
      compared++;
      if ({o_iow[n], o_ior[n], o_mw[n], o_mr[n], o_busy[n]} !== 5'b0) begin
        mismatched++;
        $display("FAIL rst_mid inst%0d: strobes/busy=%b, required 00000", n,
                 {o_iow[n], o_ior[n], o_mw[n], o_mr[n], o_busy[n]});
      end
      ex_err[n] = 1'b0;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      for (int n = 0; n < N; n++) if (o_rdv[n] || o_busy[n]) rdv_seen++;
    end
    compared++;
    if (rdv_seen !== 0) begin
      mismatched++;
      $display("FAIL rst_after: rd_valid/busy cycles=%0d, required 0", rdv_seen);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      automatic logic [3:0] mask  = 4'($urandom_range(1, 15));
      automatic logic [7:0] addr  = 8'($urandom);
      automatic logic [7:0] wdata = 8'($urandom);
      automatic logic [7:0] din   = 8'($urandom);
      automatic int         k     = $urandom_range(0, 10);
      automatic bit         br    = 1'($urandom);
      run_txn(mask, addr, wdata, din, k, 0, br);
      for (int n = 0; n < N; n++) begin
        automatic int tot = ob_cnt[n][0] + ob_cnt[n][1] + ob_cnt[n][2] + ob_cnt[n][3];
        compared++;
        if (ob_cnt[n][ex_ki] !== ex_width[n] || tot !== ex_width[n] || ob_first[n] !== 2 ||
            ob_last[n] !== ex_width[n] + 1 || ob_busy[n] !== ex_width[n] + 1) begin
          mismatched++;
          $display("FAIL rnd%0d_strobe inst%0d: sel=%0d tot=%0d first=%0d last=%0d busy=%0d, required %0d %0d 2 %0d %0d",
                   t, n, ob_cnt[n][ex_ki], tot, ob_first[n], ob_last[n], ob_busy[n],
                   ex_width[n], ex_width[n], ex_width[n] + 1, ex_width[n] + 1);
        end
        compared++;
        if (ob_addr1[n] !== addr || ob_dout1[n] !== wdata || ob_addr_end[n] !== addr) begin
          mismatched++;
          $display("FAIL rnd%0d_addr inst%0d: addr=%h dout=%h end=%h, required %h %h %h",
                   t, n, ob_addr1[n], ob_dout1[n], ob_addr_end[n], addr, wdata, addr);
        end
        compared++;
        if (ob_rdv[n] !== (ex_rd ? 1 : 0) ||
            (ex_rd && (ob_rdv_idx[n] !== ex_width[n] + 2 || ob_rdd[n] !== (ex_tmo[n] ? 8'hFF : din)))) begin
          mismatched++;
          $display("FAIL rnd%0d_read inst%0d: pulses=%0d at=%0d data=%h, required %0d at %0d data %h",
                   t, n, ob_rdv[n], ob_rdv_idx[n], ob_rdd[n], ex_rd ? 1 : 0, ex_width[n] + 2,
                   ex_tmo[n] ? 8'hFF : din);
        end
        compared++;
        if (ob_err[n] !== ex_err[n]) begin
          mismatched++;
          $display("FAIL rnd%0d_err inst%0d: err=%b, required %b", t, n, ob_err[n], ex_err[n]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_min_latency_write();
    test_wait_states();
    test_ack();
    test_timeout();
    test_priority_busy();
    test_reset_mid_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
